// File: rtl/change_dispenser.sv
// Coin-return dispenser: breaks a change amount into dollar/quarter/dime/nickel
// eject pulses, largest coin first, tracking per-coin stock and any shortfall.
module change_dispenser #(
  parameter int COIN_GAP     = 1,
  parameter int DOLLAR_INIT  = 10,
  parameter int QUARTER_INIT = 20,
  parameter int DIME_INIT    = 20,
  parameter int NICKEL_INIT  = 20,
  parameter int STOCK_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dispense,
  input  logic [8:0] change,
  input  logic       restock,
  output logic       dollar_o,
  output logic       quarter_o,
  output logic       dime_o,
  output logic       nickel_o,
  output logic       busy,
  output logic       dispenseDone,
  output logic [8:0] shortfall
);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

  localparam int GAP_W = (COIN_GAP > 1) ? $clog2(COIN_GAP) : 1;
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'((COIN_GAP > 0) ? COIN_GAP - 1 : 0);
  localparam logic [STOCK_W-1:0] STOCK_ONE = STOCK_W'(1);

  state_t             state;
  logic [8:0]         remaining;
  logic [GAP_W-1:0]   gapCnt;
  logic [STOCK_W-1:0] dollarStock, quarterStock, dimeStock, nickelStock;
  logic               pickDollar, pickQuarter, pickDime, pickNickel, anyPick;

  // Greedy choice: a coin is eligible only if it fits in remaining and is in stock,
  // which is what keeps both remaining and the stock counters from underflowing.
  always_comb begin
    pickDollar  = (remaining >= 9'd100) && (dollarStock != '0);
    pickQuarter = !pickDollar && (remaining >= 9'd25) && (quarterStock != '0);
    pickDime    = !pickDollar && !pickQuarter && (remaining >= 9'd10) && (dimeStock != '0);
    pickNickel  = !pickDollar && !pickQuarter && !pickDime &&
                  (remaining >= 9'd5) && (nickelStock != '0);
    anyPick     = pickDollar | pickQuarter | pickDime | pickNickel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      remaining    <= '0;
      gapCnt       <= '0;
      dollar_o     <= 1'b0;
      quarter_o    <= 1'b0;
      dime_o       <= 1'b0;
      nickel_o     <= 1'b0;
      busy         <= 1'b0;
      dispenseDone <= 1'b0;
      shortfall    <= '0;
      dollarStock  <= STOCK_W'(DOLLAR_INIT);
      quarterStock <= STOCK_W'(QUARTER_INIT);
      dimeStock    <= STOCK_W'(DIME_INIT);
      nickelStock  <= STOCK_W'(NICKEL_INIT);
    end else begin
      case (state)
        IDLE: begin
          if (dispense) begin
            remaining <= change;
            busy      <= 1'b1;
            state     <= SELECT;
          end else if (restock) begin
            dollarStock  <= STOCK_W'(DOLLAR_INIT);
            quarterStock <= STOCK_W'(QUARTER_INIT);
            dimeStock    <= STOCK_W'(DIME_INIT);
            nickelStock  <= STOCK_W'(NICKEL_INIT);
          end
        end
        // The coin output is registered here so it is high exactly during PULSE.
        SELECT: begin
          if (anyPick) begin
            dollar_o  <= pickDollar;
            quarter_o <= pickQuarter;
            dime_o    <= pickDime;
            nickel_o  <= pickNickel;
            state     <= PULSE;
          end else begin
            shortfall    <= remaining;
            busy         <= 1'b0;
            dispenseDone <= 1'b1;
            state        <= DONE;
          end
        end
        PULSE: begin
          dollar_o  <= 1'b0;
          quarter_o <= 1'b0;
          dime_o    <= 1'b0;
          nickel_o  <= 1'b0;
          if (dollar_o) begin
            remaining   <= remaining - 9'd100;
            dollarStock <= dollarStock - STOCK_ONE;
          end else if (quarter_o) begin
            remaining    <= remaining - 9'd25;
            quarterStock <= quarterStock - STOCK_ONE;
          end else if (dime_o) begin
            remaining <= remaining - 9'd10;
            dimeStock <= dimeStock - STOCK_ONE;
          end else if (nickel_o) begin
            remaining   <= remaining - 9'd5;
            nickelStock <= nickelStock - STOCK_ONE;
          end
          gapCnt <= '0;
          state  <= (COIN_GAP == 0) ? SELECT : GAP;
        end
        GAP: begin
          if (gapCnt == GAP_LAST) state <= SELECT;
          else gapCnt <= gapCnt + GAP_W'(1);
        end
        DONE: begin
          if (!dispense) begin
            dispenseDone <= 1'b0;
            shortfall    <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: three instances with different stock
// and gap settings, expected coin pulses queued at request time.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       dispenseV[3];
  logic [8:0] changeV[3];
  logic       restockV[3];
  logic       dollarV[3], quarterV[3], dimeV[3], nickelV[3];
  logic       busyV[3], doneV[3];
  logic [8:0] shortfallV[3];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {int dut; int coin; int cyc;} exp_t;
  exp_t expQ[$];

  int stkInit[3][4] = '{'{10, 20, 20, 20}, '{0, 0, 20, 20}, '{1, 20, 20, 20}};
  int stk[3][4];
  int gapOf[3] = '{1, 1, 0};
  int coinVal[4] = '{100, 25, 10, 5};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  change_dispenser dutA (
    .clk(clk), .rst(rst), .dispense(dispenseV[0]), .change(changeV[0]), .restock(restockV[0]),
    .dollar_o(dollarV[0]), .quarter_o(quarterV[0]), .dime_o(dimeV[0]), .nickel_o(nickelV[0]),
    .busy(busyV[0]), .dispenseDone(doneV[0]), .shortfall(shortfallV[0])
  );

  change_dispenser #(.DOLLAR_INIT(0), .QUARTER_INIT(0)) dutB (
    .clk(clk), .rst(rst), .dispense(dispenseV[1]), .change(changeV[1]), .restock(restockV[1]),
    .dollar_o(dollarV[1]), .quarter_o(quarterV[1]), .dime_o(dimeV[1]), .nickel_o(nickelV[1]),
    .busy(busyV[1]), .dispenseDone(doneV[1]), .shortfall(shortfallV[1])
  );

  change_dispenser #(.DOLLAR_INIT(1), .COIN_GAP(0)) dutC (
    .clk(clk), .rst(rst), .dispense(dispenseV[2]), .change(changeV[2]), .restock(restockV[2]),
    .dollar_o(dollarV[2]), .quarter_o(quarterV[2]), .dime_o(dimeV[2]), .nickel_o(nickelV[2]),
    .busy(busyV[2]), .dispenseDone(doneV[2]), .shortfall(shortfallV[2])
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic int coinsOf(input int d);
    return int'({dollarV[d], quarterV[d], dimeV[d], nickelV[d]});
  endfunction

  task automatic resetModel(input int d);
    for (int k = 0; k < 4; k++) stk[d][k] = stkInit[d][k];
  endtask

  // Greedy reference: queues each expected coin with the cycle it should appear.
  task automatic pushExpected(input int d, input int amount, input int acc,
                              output int n, output int sf);
    int rem;
    bool_loop: begin
      rem = amount;
      n = 0;
      forever begin
        int pick;
        pick = -1;
        for (int k = 0; k < 4; k++)
          if (pick < 0 && coinVal[k] <= rem && stk[d][k] > 0) pick = k;
        if (pick < 0) break;
        expQ.push_back('{dut: d, coin: (8 >> pick), cyc: acc + 2 + n * (gapOf[d] + 2)});
        rem -= coinVal[pick];
        stk[d][pick]--;
        n++;
      end
    end
    sf = rem;
  endtask

  // Every coin pulse on any instance must match the head of the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (coinsOf(d) != 0) begin
        if (expQ.size() == 0) begin
          checkOutput("spuriousCoin", coinsOf(d), 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("coinDut", d, e.dut);
          checkOutput("coinType", coinsOf(d), e.coin);
          checkOutput("coinCycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic applyStimulus(input int d, input int amount, input bit dropEarly);
    int acc, n, sf, expDone, guard;
    @(negedge clk);
    dispenseV[d] = 1'b1;
    changeV[d]   = 9'(amount);
    acc = cyc;
    pushExpected(d, amount, acc, n, sf);
    expDone = acc + 2 + n * (gapOf[d] + 2);
    @(negedge clk);
    checkOutput("busyAfterAccept", busyV[d], 1);
    if (dropEarly) begin
      dispenseV[d] = 1'b0;
      changeV[d]   = 9'h0AA;
    end
    guard = 0;
    while (!doneV[d] && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("doneCycle", cyc, expDone);
    checkOutput("shortfall", shortfallV[d], sf);
    checkOutput("busyInDone", busyV[d], 0);
    if (!dropEarly) begin
      @(negedge clk);
      checkOutput("doneHeld", doneV[d], 1);
      dispenseV[d] = 1'b0;
    end
    @(negedge clk);
    checkOutput("doneClear", doneV[d], 0);
    checkOutput("shortfallClear", shortfallV[d], 0);
  endtask

  initial begin
    int acc, n, sf;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      dispenseV[d] = 1'b0;
      changeV[d]   = '0;
      restockV[d]  = 1'b0;
      resetModel(d);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput("resetCoins", coinsOf(d), 0);
      checkOutput("resetBusy", busyV[d], 0);
      checkOutput("resetDone", doneV[d], 0);
      checkOutput("resetShortfall", shortfallV[d], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(0, 140, 1'b0);
    applyStimulus(0, 7, 1'b0);
    applyStimulus(0, 0, 1'b0);

    applyStimulus(1, 50, 1'b0);
    applyStimulus(1, 511, 1'b0);

    applyStimulus(2, 100, 1'b0);
    applyStimulus(2, 100, 1'b0);
    @(negedge clk);
    restockV[2] = 1'b1;
    @(negedge clk);
    restockV[2] = 1'b0;
    resetModel(2);
    applyStimulus(2, 100, 1'b0);
    applyStimulus(2, 100, 1'b0);

    applyStimulus(0, 140, 1'b1);

    // Reset lands during the second coin pulse; remaining coins must never appear.
    @(negedge clk);
    dispenseV[0] = 1'b1;
    changeV[0]   = 9'd140;
    acc = cyc;
    pushExpected(0, 140, acc, n, sf);
    while (cyc < acc + 5) @(negedge clk);
    #1;
    checkOutput("pendingAtReset", expQ.size(), 2);
    expQ.delete();
    rst = 1'b1;
    dispenseV[0] = 1'b0;
    @(negedge clk);
    checkOutput("abortCoins", coinsOf(0), 0);
    checkOutput("abortBusy", busyV[0], 0);
    checkOutput("abortDone", doneV[0], 0);
    checkOutput("abortShortfall", shortfallV[0], 0);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) resetModel(d);
    repeat (10) @(negedge clk);
    applyStimulus(2, 100, 1'b0);

    repeat (2) @(negedge clk);
    checkOutput("queueEmpty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Coin-return end of the vending payment path. The payment block accumulates inserted coins and reports a change amount on cancel or after a purchase. This block turns that amount into individual coin-eject pulses: dollar, quarter, dime and nickel, largest coin first. It tracks per-coin stock, reports any amount it cannot pay, and completes a 4-phase request/done handshake.

Parameters:
COIN_GAP, 1, idle cycles with all coin outputs low between consecutive coin pulses (must be >=0)
DOLLAR_INIT, 10, dollar-coin stock after reset/restock
QUARTER_INIT, 20, quarter stock after reset/restock
DIME_INIT, 20, dime stock after reset/restock
NICKEL_INIT, 20, nickel stock after reset/restock
STOCK_W, 8, width of each stock counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
dispense  input  1  change request; level, held until dispenseDone seen
change  input  9  amount in cents, sampled only on request accept
restock  input  1  reload all stock counters to *_INIT; honoured only in IDLE
dollar_o  output  1  one-cycle eject pulse, 100c
quarter_o  output  1  one-cycle eject pulse, 25c
dime_o  output  1  one-cycle eject pulse, 10c
nickel_o  output  1  one-cycle eject pulse, 5c
busy  output  1  high from accept until DONE is entered
dispenseDone  output  1  request complete; held while dispense stays high
shortfall  output  9  cents not paid; valid while dispenseDone=1

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, all outputs 0, remaining=0, stocks=*_INIT. Reset mid-dispense aborts immediately, with no further pulses.
- All outputs are registered. At most one coin output is high in any cycle.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE: if dispense=1, latch remaining<=change and set busy=1. Go to SELECT. Otherwise, if restock=1, reload stocks.
- SELECT (1 cycle): choose the first coin in the order dollar, quarter, dime, nickel with value<=remaining and stock>0.
  - If a coin is found, go to PULSE.
  - If none is found (remaining=0, remaining<5, or coins exhausted), set shortfall<=remaining, busy<=0, dispenseDone<=1, and go to DONE.
- PULSE (1 cycle): the chosen coin output is high for exactly this cycle. Subtract its value from remaining and decrement its stock. Go to GAP, or straight to SELECT if COIN_GAP=0.
- GAP: hold COIN_GAP cycles with all coin outputs low, then go to SELECT.
- Timing:
  - First pulse appears 2 cycles after the accept edge.
  - Pulse period is COIN_GAP+2 cycles.
  - dispenseDone rises 1 cycle after the final SELECT decision.
  - change=0 gives dispenseDone 2 cycles after accept, with no pulses.
- DONE: hold dispenseDone=1 and shortfall until dispense=0. Then clear dispenseDone and shortfall to 0 and return to IDLE.
- Inputs ignored outside their window:
  - change is ignored after accept.
  - dispense dropping before DONE is ignored; the operation completes.
  - restock outside IDLE is ignored.
- Arithmetic is 9-bit unsigned. remaining never underflows, because a coin is chosen only if its value<=remaining. Stock counters never go below 0.
- Stock persists across requests; only reset or restock replenishes it.

Test Plan:
- Default params, COIN_GAP=1, change=140, dispense held → pulses dollar, quarter, dime, nickel in that order, 3 cycles apart (first at accept+2); dispenseDone=1, shortfall=0; drop dispense → dispenseDone=0 next cycle, IDLE.
- QUARTER_INIT=0, change=50 → five dime pulses, no quarter pulse; shortfall=0; dime stock ends at 15.
- change=7 → one nickel pulse, then dispenseDone with shortfall=2.
- change=0 → no coin pulses, dispenseDone at accept+2, shortfall=0, busy low throughout DONE.
- DOLLAR_INIT=1: two requests of change=100 → first request gives one dollar pulse; second gives four quarter pulses. restock in IDLE, third request of 100 → one dollar pulse again.
- Reset asserted during the second coin pulse of change=140 → all outputs 0 next cycle, no further pulses, stocks back to INIT. Separately: change altered and dispense dropped mid-operation → original amount still fully dispensed.
